// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control with a RAW scoreboard for the non-forwarding 5-stage RV32I pipe.
// Optional WB_BYPASS_EN: the register file is write-first, so the WB entry is not hazard-checked.
module hazard_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_id_inst,
    input  logic        i_ex_redirect,
    input  logic        i_mem_hold,
    output logic        o_pc_stall,
    output logic        o_if_id_stall,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_pipe_hold,
    output logic        o_raw_hazard
);
`ifdef WB_BYPASS_EN
    localparam int CHK = 2;
`else
    localparam int CHK = 3;
`endif
    logic [6:0] opc;
    logic [4:0] rs1, rs2, rd;
    logic       use_rs1, use_rs2, wr_rd, hit1, hit2, raw, v0_d;
    logic [2:0] v_q;
    logic [4:0] rd_q [3];
    logic       unused_bits;
    assign opc         = i_id_inst[6:0];
    assign rd          = i_id_inst[11:7];
    assign rs1         = i_id_inst[19:15];
    assign rs2         = i_id_inst[24:20];
    assign unused_bits = ^{i_id_inst[31:25], i_id_inst[14:12]};
    assign use_rs1 = opc inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    assign use_rs2 = opc inside {7'b1100011, 7'b0100011, 7'b0110011};
    assign wr_rd   = opc inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0110011};
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < CHK; k++) begin
            hit1 = hit1 | (v_q[k] & (rd_q[k] == rs1));
            hit2 = hit2 | (v_q[k] & (rd_q[k] == rs2));
        end
    end
    assign raw  = (use_rs1 && rs1 != 5'd0 && hit1) || (use_rs2 && rs2 != 5'd0 && hit2);
    // Only an instruction that actually leaves ID enters the scoreboard.
    assign v0_d = !raw && !i_ex_redirect && wr_rd && rd != 5'd0;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v_q <= '0;
        end else if (!i_mem_hold) begin
            v_q      <= {v_q[1:0], v0_d};
            rd_q[2]  <= rd_q[1];
            rd_q[1]  <= rd_q[0];
            rd_q[0]  <= rd;
        end
    end
    assign o_pipe_hold   = i_rst_n && i_mem_hold;
    assign o_pc_stall    = i_rst_n && (i_mem_hold || (!i_ex_redirect && raw));
    assign o_if_id_stall = o_pc_stall;
    assign o_if_id_flush = !i_rst_n || (!i_mem_hold && i_ex_redirect);
    assign o_id_ex_flush = !i_rst_n || (!i_mem_hold && (i_ex_redirect || raw));
    assign o_raw_hazard  = i_rst_n && raw;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table for the documented corner cases, then random traffic vs a countdown model.
module tb_hazard_ctrl;
`ifdef WB_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif
    localparam logic [31:0] NOP = 32'h0000_0000, ADDI5 = 32'h0010_0293, ADD6 = 32'h0052_8333,
        ADDI0 = 32'h0010_0013, ADD7_00 = 32'h0000_03B3, ADD7_66 = 32'h0063_03B3,
        LUI5 = 32'h0000_12B7, JAL1 = 32'h0080_00EF, LW8 = 32'h0001_2403,
        SW8 = 32'h0081_2223, BEQ38 = 32'h0081_8463;
    localparam logic [5:0] E_RST = 6'b001100, E_STALL = 6'b110101, E_HOLD = 6'b110010,
        E_REDIR = 6'b001100, E_NONE = 6'b000000;
    typedef struct {
        logic        rst_n;
        logic [31:0] inst;
        logic        redir;
        logic        hold;
        logic [5:0]  exp;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        redir = 1'b0, hold = 1'b0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, raw_hz;
    int          n_vec = 0, n_err = 0;
    int          cnt [32];
    vec_t        tv [$];
    hazard_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_inst(inst), .i_ex_redirect(redir), .i_mem_hold(hold),
        .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
        .o_id_ex_flush(id_ex_flush), .o_pipe_hold(pipe_hold), .o_raw_hazard(raw_hz)
    );
    always #5 clk = ~clk;
    // Model: a register stays unreadable for LAT cycles after its producer leaves ID.
    function automatic logic m_raw(input logic [31:0] x);
        logic [6:0] op;
        logic       u1, u2;
        op = x[6:0];
        u1 = 1'b0;
        u2 = 1'b0;
        case (op)
            7'b1100011, 7'b0100011, 7'b0110011: begin u1 = 1'b1; u2 = 1'b1; end
            7'b1100111, 7'b0000011, 7'b0010011: u1 = 1'b1;
            default: ;
        endcase
        return (u1 && x[19:15] != 0 && cnt[x[19:15]] > 0) || (u2 && x[24:20] != 0 && cnt[x[24:20]] > 0);
    endfunction
    function automatic logic m_wr(input logic [31:0] x);
        return x[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0110011}
               && x[11:7] != 0;
    endfunction
    function automatic logic [5:0] m_exp(input logic r, input logic [31:0] x, input logic rd_, input logic h);
        logic hz;
        hz = m_raw(x);
        if (!r)  return E_RST;
        if (h)   return E_HOLD | {5'b0, hz};
        if (rd_) return E_REDIR | {5'b0, hz};
        if (hz)  return E_STALL;
        return E_NONE;
    endfunction
    always @(posedge clk) begin
        logic iss;
        iss = !m_raw(inst) && !redir && m_wr(inst);
        if (!rst_n) begin
            foreach (cnt[i]) cnt[i] = 0;
        end else if (!hold) begin
            foreach (cnt[i]) if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
            if (iss) cnt[inst[11:7]] = LAT;
        end
    end
    task automatic add(input logic r, input logic [31:0] x, input logic rd_, input logic h, input logic [5:0] e, input int n = 1);
        for (int i = 0; i < n; i++) tv.push_back('{r, x, rd_, h, e});
    endtask
    task automatic apply(input logic r, input logic [31:0] x, input logic rd_, input logic h);
        @(negedge clk);
        rst_n = r;
        inst  = x;
        redir = rd_;
        hold  = h;
        #1;
    endtask
    task automatic check(input string nm, input logic [5:0] e);
        logic [5:0] got;
        got = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, raw_hz};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (pc_st,ifid_st,ifid_fl,idex_fl,hold,raw)", nm, got, e);
        end
    endtask
    initial begin
        add(0, ADD6, 0, 0, E_RST, 2);
        add(1, ADD6, 0, 0, E_NONE);
        add(1, ADDI5, 0, 0, E_NONE);
        add(1, ADD6, 0, 0, E_STALL, LAT);
        add(1, ADD6, 0, 0, E_NONE);
        add(1, ADD7_00, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, ADDI0, 0, 0, E_NONE);
        add(1, ADD7_00, 0, 0, E_NONE);
        add(1, LUI5, 0, 0, E_NONE);
        add(1, JAL1, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, ADDI5, 0, 0, E_NONE);
        add(1, ADD6, 1, 0, E_REDIR | 6'b000001);
        add(1, ADD7_66, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, ADDI5, 0, 0, E_NONE);
        add(1, ADD6, 0, 1, E_HOLD | 6'b000001, 4);
        add(1, ADD6, 0, 0, E_STALL, LAT);
        add(1, ADD6, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, LW8, 0, 0, E_NONE);
        add(1, SW8, 0, 0, E_STALL, LAT);
        add(1, SW8, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, LW8, 0, 0, E_NONE);
        add(1, BEQ38, 0, 0, E_STALL, LAT);
        add(1, BEQ38, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, ADDI5, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE);
        add(1, ADD6, 0, 0, E_STALL, LAT - 1);
        add(1, ADD6, 0, 0, E_NONE);
        add(1, NOP, 0, 0, E_NONE, 3);
        add(1, ADDI5, 0, 0, E_NONE);
        add(1, ADD6, 0, 0, E_STALL);
        add(0, ADD6, 0, 0, E_RST);
        add(1, ADD6, 0, 0, E_NONE);
        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].rst_n, tv[i].inst, tv[i].redir, tv[i].hold);
            check($sformatf("tv[%0d]", i), tv[i].exp);
        end
        apply(0, NOP, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ops [11];
            logic [31:0] x;
            ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                    7'b0100011, 7'b0010011, 7'b0110011, 7'b0000000, 7'b1110011};
            x = $urandom;
            x[6:0]   = ops[$urandom_range(0, 10)];
            x[11:7]  = 5'($urandom_range(0, 7));
            x[19:15] = 5'($urandom_range(0, 7));
            x[24:20] = 5'($urandom_range(0, 7));
            apply($urandom_range(0, 99) >= 3, x, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
            check($sformatf("rand[%0d]", i), m_exp(rst_n, inst, redir, hold));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
